// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and operand entry.
package keypad_pkg;

    localparam int ROWS         = 4;
    localparam int COLS         = 4;
    localparam int CODE_W       = 4;
    localparam int ENTRY_DIGITS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Lowest-index low row wins when several rows are pressed in one column.
    function automatic logic [1:0] first_low_row(input logic [ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row returns; idles released (all high).
module row_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_entry.sv
// Column-scanned 4x4 keypad with per-key debounce, one event per press, and a
// four-digit hex operand shift register.
//
// state    | meaning
// SCAN     | rotating columns, waiting for any low row at the sample point
// DEBOUNCE | candidate key latched, counting matching samples on this column
// HELD     | key accepted, waiting for an all-high sample
// RELEASE  | counting all-high samples before returning to SCAN
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE_N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   row_in,
    input  logic              entry_clear,
    output logic [COLS-1:0]   col_out,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held,
    output logic [15:0]       entry,
    output logic [2:0]        digit_count,
    output logic              entry_full
);

    localparam int              SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [7:0]      DB_N      = 8'(DEBOUNCE_N);
    localparam logic [2:0]      DIG_MAX   = 3'(ENTRY_DIGITS);

    logic [ROWS-1:0]   row_s;
    logic [SLOT_W-1:0] slot_q;
    logic              sample;
    logic [1:0]        col_q;
    logic [COLS-1:0]   col_out_q;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;

    logic              any_low;
    logic [CODE_W-1:0] win_code;

    logic              accept, release_done, advance;
    logic [15:0]       entry_q, entry_d;
    logic [2:0]        count_q, count_d;
    logic              full_q;
    logic              key_valid_q, key_held_q;
    logic [CODE_W-1:0] key_code_q;

    row_sync u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_in),
        .q_o   (row_s)
    );

    assign sample   = (slot_q == SLOT_LAST);
    assign any_low  = ~&row_s;
    assign win_code = {first_low_row(row_s), col_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= '0;
            col_q     <= 2'd0;
            col_out_q <= 4'b1110;
            state_q   <= SCAN;
            cnt_q     <= 8'd0;
            cand_q    <= '0;
        end else begin
            slot_q  <= sample ? '0 : slot_q + 1'b1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            if (advance) begin
                col_q     <= col_q + 2'd1;
                col_out_q <= {col_out_q[COLS-2:0], col_out_q[COLS-1]};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        cand_d  = win_code;
                        cnt_d   = 8'd1;
                        state_d = (DB_N == 8'd1) ? HELD : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && (win_code == cand_q)) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == DB_N) state_d = HELD;
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!any_low) begin
                        cnt_d   = 8'd1;
                        state_d = (DB_N == 8'd1) ? SCAN : RELEASE;
                    end
                end
                RELEASE: begin
                    if (!any_low) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == DB_N) state_d = SCAN;
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // Entry update happens on the accepting edge so it lines up with key_valid.
    always_comb begin
        accept       = sample && (state_d == HELD) &&
                       ((state_q == SCAN) || (state_q == DEBOUNCE));
        release_done = sample && (state_d == SCAN) &&
                       ((state_q == HELD) || (state_q == RELEASE));
        advance      = sample && (state_d == SCAN);
        entry_d      = entry_q;
        count_d      = count_q;
        if (entry_clear) begin
            entry_d = 16'h0000;
            count_d = 3'd0;
        end else if (accept && (count_q < DIG_MAX)) begin
            entry_d = {entry_q[11:0], cand_d};
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            entry_q     <= 16'h0000;
            count_q     <= 3'd0;
            full_q      <= 1'b0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= cand_d;
                key_held_q <= 1'b1;
            end else if (release_done) begin
                key_held_q <= 1'b0;
            end
            entry_q <= entry_d;
            count_q <= count_d;
            full_q  <= (count_d == DIG_MAX);
        end
    end

    assign col_out     = col_out_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_held    = key_held_q;
    assign entry       = entry_q;
    assign digit_count = count_q;
    assign entry_full  = full_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a matrix model drives rows from col_out and
// pressed keys; expectations are hand-computed codes and entry values.
module tb_keypad_entry;

    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE_N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        entry_clear = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] entry;
    logic [2:0]  digit_count;
    logic        entry_full;

    logic [15:0] key_mask = '0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          ev_cnt = 0;
    int          dbl_cnt = 0;
    logic        vld_prev = 1'b0;
    int          tb_slot;
    int          ev0;

    always #5 clk = ~clk;

    keypad_entry #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE_N (DEBOUNCE_N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_in      (row_in),
        .entry_clear (entry_clear),
        .col_out     (col_out),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_held    (key_held),
        .entry       (entry),
        .digit_count (digit_count),
        .entry_full  (entry_full)
    );

    // Passive matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_out[c] && key_mask[r*4+c]) row_in[r] = 1'b0;
    end

    // Slot phase used only to time bounce stimulus against the sample points.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_slot <= 0;
        else        tb_slot <= (tb_slot == SCAN_DIV - 1) ? 0 : tb_slot + 1;
    end

    always @(negedge clk) begin
        if (key_valid) ev_cnt <= ev_cnt + 1;
        if (key_valid && vld_prev) dbl_cnt <= dbl_cnt + 1;
        vld_prev <= key_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_event(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
        chk({tag, "_event"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_release(input string tag, input int budget);
        bit gone;
        gone = 1'b0;
        for (int i = 0; i < budget && !gone; i++) begin
            @(negedge clk);
            if (!key_held) gone = 1'b1;
        end
        chk({tag, "_release"}, 32'(gone), 32'd1);
    endtask

    task automatic wait_sample();
        for (int i = 0; i < SCAN_DIV + 1; i++) begin
            @(negedge clk);
            if (tb_slot == SCAN_DIV - 1) begin
                @(posedge clk);
                #1;
                break;
            end
        end
    endtask

    task automatic tap(input int code, input string tag);
        key_mask[code] = 1'b1;
        wait_event(tag, 100);
        chk({tag, "_code"}, 32'(key_code), 32'(code));
        key_mask = '0;
        wait_release(tag, 100);
    endtask

    initial begin
        logic [3:0] exp_col;

        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col_out), 32'hE);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        chk("rst_entry", 32'(entry), 32'd0);
        chk("rst_count", 32'(digit_count), 32'd0);
        chk("rst_full", 32'(entry_full), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 17; k++) begin
            exp_col = ~(4'(1) << ((k / 4) % 4));
            chk("idle_col", 32'(col_out), 32'(exp_col));
            @(negedge clk);
        end
        chk("idle_no_event", 32'(ev_cnt), 32'd0);

        // Clean press, row 2 / col 1
        ev0 = ev_cnt;
        key_mask[9] = 1'b1;
        wait_event("press9", 100);
        chk("press9_code", 32'(key_code), 32'd9);
        chk("press9_held", 32'(key_held), 32'd1);
        chk("press9_entry", 32'(entry), 32'h0009);
        chk("press9_count", 32'(digit_count), 32'd1);
        chk("press9_full", 32'(entry_full), 32'd0);
        repeat (200) @(negedge clk);
        chk("press9_once", 32'(ev_cnt - ev0), 32'd1);
        chk("press9_still_held", 32'(key_held), 32'd1);
        key_mask = '0;
        repeat (6) @(negedge clk);
        chk("press9_held_during_rel", 32'(key_held), 32'd1);
        wait_release("press9", 100);

        // Bounce on key 6 (row 1 / col 2): one low sample, one high sample
        for (int i = 0; i < 24; i++) begin
            wait_sample();
            if (col_out == 4'b1011) break;
        end
        chk("bounce_align", 32'(col_out), 32'hB);
        ev0 = ev_cnt;
        key_mask[6] = 1'b1;
        wait_sample();
        key_mask = '0;
        wait_sample();
        wait_sample();
        chk("bounce_no_event", 32'(ev_cnt - ev0), 32'd0);
        chk("bounce_not_held", 32'(key_held), 32'd0);
        key_mask[6] = 1'b1;
        wait_event("bounce6", 100);
        chk("bounce6_code", 32'(key_code), 32'd6);
        chk("bounce6_entry", 32'(entry), 32'h0096);
        repeat (20) @(negedge clk);
        chk("bounce6_once", 32'(ev_cnt - ev0), 32'd1);
        key_mask = '0;
        wait_release("bounce6", 100);

        // Rows 1 and 3 together in column 0
        key_mask[4]  = 1'b1;
        key_mask[12] = 1'b1;
        wait_event("multi", 100);
        chk("multi_code", 32'(key_code), 32'd4);
        chk("multi_entry", 32'(entry), 32'h0964);
        chk("multi_count", 32'(digit_count), 32'd3);
        key_mask = '0;
        wait_release("multi", 100);

        // Clear, then five keys: fifth is ignored by the entry register
        entry_clear = 1'b1;
        @(negedge clk);
        entry_clear = 1'b0;
        chk("clr_entry", 32'(entry), 32'd0);
        chk("clr_count", 32'(digit_count), 32'd0);
        for (int i = 1; i <= 5; i++) tap(i, "seq");
        chk("seq_entry", 32'(entry), 32'h1234);
        chk("seq_count", 32'(digit_count), 32'd4);
        chk("seq_full", 32'(entry_full), 32'd1);

        // Clear held across the accepting edge wins over the new digit
        entry_clear = 1'b1;
        key_mask[7] = 1'b1;
        wait_event("clrwin", 100);
        chk("clrwin_code", 32'(key_code), 32'd7);
        chk("clrwin_entry", 32'(entry), 32'd0);
        chk("clrwin_count", 32'(digit_count), 32'd0);
        entry_clear = 1'b0;
        @(negedge clk);
        chk("clrwin_full", 32'(entry_full), 32'd0);
        key_mask = '0;
        wait_release("clrwin", 100);

        // Reset while key 3 is held: fresh event after re-debounce
        key_mask[3] = 1'b1;
        wait_event("rstkey", 100);
        chk("rstkey_entry", 32'(entry), 32'h0003);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_held", 32'(key_held), 32'd0);
        chk("midrst_entry", 32'(entry), 32'd0);
        chk("midrst_col", 32'(col_out), 32'hE);
        rst_n = 1'b1;
        ev0 = ev_cnt;
        wait_event("rearm", 100);
        chk("rearm_code", 32'(key_code), 32'd3);
        chk("rearm_entry", 32'(entry), 32'h0003);
        chk("rearm_count", 32'(digit_count), 32'd1);
        chk("rearm_held", 32'(key_held), 32'd1);
        repeat (10) @(negedge clk);
        chk("rearm_once", 32'(ev_cnt - ev0), 32'd1);
        key_mask = '0;
        wait_release("rearm", 100);

        chk("single_cycle_pulses", 32'(dbl_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
